photo_int_pulse_meter: RTL and testbench

Front-end measurement stage for the photo-interrupter (wheel encoder) channel of the EV controller. It synchronises and debounces the raw slot-sensor input, counts rising edges, and measures edge-to-edge period and pulses-per-gate-window. Its outputs feed the register bank of the AXI4-Lite PHOTO_INT_CNTR peripheral directly, which exposes them to software and drives the interrupt line.

---
 rtl/photo_int_pulse_meter.sv | 212 +++++++++++++++++++++
 tb/tb_photo_int_pulse_meter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/photo_int_pulse_meter.sv
// photo_int_pulse_meter
// Measurement front end for the wheel-encoder photo-interrupter: 2-FF sync,
// level debounce, rising-edge counting, edge-to-edge period and per-window
// edge count, plus a sticky window-close interrupt request.
module photo_int_pulse_meter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GATE_CYCLES     = 100000000,
    parameter int TOTAL_W         = 32,
    parameter int WIN_W           = 16,
    parameter int PER_W           = 32
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               photo_in,
    input  logic               enable,
    input  logic               clr,
    input  logic               irq_en,
    input  logic               irq_ack,
    output logic [TOTAL_W-1:0] total_cnt,
    output logic [WIN_W-1:0]   win_cnt,
    output logic               win_done,
    output logic [PER_W-1:0]   period,
    output logic               period_valid,
    output logic               stalled,
    output logic               irq
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GT_W = $clog2(GATE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GT_W-1:0] GT_LAST = GT_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    // Window accumulator never wraps: a stuck-at-max count is more useful
    // to software than a small wrapped one.
    function automatic logic [WIN_W-1:0] win_sat_add(input logic [WIN_W-1:0] v,
                                                     input logic             inc);
        if (inc && (v != '1)) return v + WIN_W'(1);
        return v;
    endfunction

    // Period timer clamps at all-ones; that value doubles as the stall marker.
    function automatic logic [PER_W-1:0] per_sat_inc(input logic [PER_W-1:0] v);
        if (v == '1) return v;
        return v + PER_W'(1);
    endfunction

    logic               sync1_q, sync2_q;
    logic               deb_q, deb_d, deb_prev_q;
    logic [DB_W-1:0]    stab_q, stab_d;
    logic               edge_evt;

    state_t             state_q, state_d;
    logic [GT_W-1:0]    gate_q, gate_d;
    logic [WIN_W-1:0]   acc_q, acc_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic               win_done_q, win_done_d;
    logic [PER_W-1:0]   period_q, period_d;
    logic               period_valid_q, period_valid_d;
    logic               stalled_q, stalled_d;
    logic               irq_q, irq_d;

    // Debouncer: accept the synchronised level only after it has differed
    // from the current debounced level for DEBOUNCE_CYCLES samples in a row.
    always_comb begin
        stab_d = stab_q;
        deb_d  = deb_q;
        if (sync2_q != deb_q) begin
            if (stab_q == DB_LAST) begin
                deb_d  = sync2_q;
                stab_d = '0;
            end else begin
                stab_d = stab_q + DB_W'(1);
            end
        end else begin
            stab_d = '0;
        end
    end

    // An edge event is one cycle wide, on the debounced 0->1 transition.
    assign edge_evt = deb_q & ~deb_prev_q;

    // Measurement FSM and counters; clr takes priority over everything,
    // enable low parks the FSM in IDLE with all values held.
    always_comb begin
        state_d        = state_q;
        gate_d         = gate_q;
        acc_d          = acc_q;
        per_d          = per_q;
        total_d        = total_q;
        win_cnt_d      = win_cnt_q;
        win_done_d     = 1'b0;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        stalled_d      = stalled_q;

        if (clr) begin
            state_d        = enable ? ARMED : IDLE;
            gate_d         = '0;
            acc_d          = '0;
            per_d          = '0;
            total_d        = '0;
            win_cnt_d      = '0;
            period_d       = '0;
            period_valid_d = 1'b0;
            stalled_d      = 1'b0;
        end else if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // Re-arming starts a fresh measurement: the first edge
                    // seen afterwards only restarts the period timer.
                    state_d        = ARMED;
                    period_valid_d = 1'b0;
                end
                ARMED, MEASURE: begin
                    if (edge_evt) total_d = total_q + TOTAL_W'(1);

                    // An edge landing on the terminal cycle closes with its window.
                    if (gate_q == GT_LAST) begin
                        gate_d     = '0;
                        win_cnt_d  = win_sat_add(acc_q, edge_evt);
                        acc_d      = '0;
                        win_done_d = 1'b1;
                    end else begin
                        gate_d = gate_q + GT_W'(1);
                        acc_d  = win_sat_add(acc_q, edge_evt);
                    end

                    if (state_q == ARMED) begin
                        if (edge_evt) begin
                            per_d   = '0;
                            state_d = MEASURE;
                        end
                    end else if (edge_evt) begin
                        period_d       = per_sat_inc(per_q);
                        period_valid_d = 1'b1;
                        stalled_d      = 1'b0;
                        per_d          = '0;
                    end else begin
                        per_d = per_sat_inc(per_q);
                        if (per_d == '1) stalled_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sticky interrupt: a window close with irq_en set beats a same-cycle ack.
    always_comb begin
        irq_d = irq_q;
        if (irq_ack) irq_d = 1'b0;
        if (win_done_q && irq_en) irq_d = 1'b1;
    end

    // State registers; reset discards any partial window or period.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            deb_q          <= 1'b0;
            deb_prev_q     <= 1'b0;
            stab_q         <= '0;
            state_q        <= IDLE;
            gate_q         <= '0;
            acc_q          <= '0;
            per_q          <= '0;
            total_q        <= '0;
            win_cnt_q      <= '0;
            win_done_q     <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            sync1_q        <= photo_in;
            sync2_q        <= sync1_q;
            deb_q          <= deb_d;
            deb_prev_q     <= deb_q;
            stab_q         <= stab_d;
            state_q        <= state_d;
            gate_q         <= gate_d;
            acc_q          <= acc_d;
            per_q          <= per_d;
            total_q        <= total_d;
            win_cnt_q      <= win_cnt_d;
            win_done_q     <= win_done_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stalled_q      <= stalled_d;
            irq_q          <= irq_d;
        end
    end

    assign total_cnt    = total_q;
    assign win_cnt      = win_cnt_q;
    assign win_done     = win_done_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stalled      = stalled_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_photo_int_pulse_meter.sv
// Bench for photo_int_pulse_meter (DEBOUNCE_CYCLES=4, GATE_CYCLES=1000,
// PER_W=8). Window results go through a queue scoreboard; everything else
// is checked inline at negedges at cycle offsets derived by hand.
module tb_photo_int_pulse_meter;

    localparam int DB   = 4;
    localparam int GATE = 1000;
    localparam int TW   = 32;
    localparam int WW   = 16;
    localparam int PW   = 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          photo_in = 1'b0;
    logic          enable = 1'b0;
    logic          clr = 1'b0;
    logic          irq_en = 1'b0;
    logic          irq_ack = 1'b0;
    logic [TW-1:0] total_cnt;
    logic [WW-1:0] win_cnt;
    logic          win_done;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          stalled;
    logic          irq;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic          sb_on = 1'b0;
    logic [WW-1:0] win_q[$];
    logic [WW-1:0] mon_exp;

    photo_int_pulse_meter #(
        .DEBOUNCE_CYCLES(DB),
        .GATE_CYCLES    (GATE),
        .TOTAL_W        (TW),
        .WIN_W          (WW),
        .PER_W          (PW)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .photo_in    (photo_in),
        .enable      (enable),
        .clr         (clr),
        .irq_en      (irq_en),
        .irq_ack     (irq_ack),
        .total_cnt   (total_cnt),
        .win_cnt     (win_cnt),
        .win_done    (win_done),
        .period      (period),
        .period_valid(period_valid),
        .stalled     (stalled),
        .irq         (irq)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Scoreboard: every win_done pops one expected window count.
    always @(negedge ACLK) begin
        if (sb_on && win_done) begin
            checks++;
            if (win_q.size() == 0) begin
                failures++;
                $display("FAIL win_done_unexpected: got win_done=1 win_cnt=%0d, expected no window close", win_cnt);
            end else begin
                mon_exp = win_q.pop_front();
                if (win_cnt !== mon_exp) begin
                    failures++;
                    $display("FAIL win_cnt: got %0d expected %0d", win_cnt, mon_exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge ACLK);
    endtask

    task automatic test_reset();
        repeat (3) begin
            photo_in = 1'b1; tick(3);
            photo_in = 1'b0; tick(3);
        end
        checks++; if (total_cnt !== '0)   begin failures++; $display("FAIL rst_total: got %0d expected 0", total_cnt); end
        checks++; if (win_cnt !== '0)     begin failures++; $display("FAIL rst_win_cnt: got %0d expected 0", win_cnt); end
        checks++; if (win_done !== 1'b0)  begin failures++; $display("FAIL rst_win_done: got %0b expected 0", win_done); end
        checks++; if (period !== '0)      begin failures++; $display("FAIL rst_period: got %0d expected 0", period); end
        checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL rst_period_valid: got %0b expected 0", period_valid); end
        checks++; if (stalled !== 1'b0)   begin failures++; $display("FAIL rst_stalled: got %0b expected 0", stalled); end
        checks++; if (irq !== 1'b0)       begin failures++; $display("FAIL rst_irq: got %0b expected 0", irq); end
        ARESETN = 1'b1;
        tick(2);
        repeat (5) begin
            photo_in = 1'b1; tick(10);
            photo_in = 1'b0; tick(10);
        end
        tick(10);
        checks++; if (total_cnt !== '0) begin failures++; $display("FAIL idle_total: got %0d expected 0", total_cnt); end
    endtask

    task automatic test_debounce(output int r0);
        enable = 1'b1;
        tick(2);
        repeat (3) begin
            photo_in = 1'b1; tick(2);
            photo_in = 1'b0; tick(8);
        end
        checks++; if (total_cnt !== '0) begin failures++; $display("FAIL glitch_total: got %0d expected 0", total_cnt); end
        r0 = cyc;
        photo_in = 1'b1;
        at(r0 + 6);
        checks++; if (total_cnt !== 32'd0) begin failures++; $display("FAIL deb_latency_early: got %0d expected 0", total_cnt); end
        at(r0 + 7);
        checks++; if (total_cnt !== 32'd1) begin failures++; $display("FAIL deb_latency: got %0d expected 1", total_cnt); end
        checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL first_edge_valid: got %0b expected 0", period_valid); end
        at(r0 + 10);
        photo_in = 1'b0;
    endtask

    task automatic test_period(input int r0);
        at(r0 + 100); photo_in = 1'b1;
        at(r0 + 107);
        checks++; if (period !== 8'd100) begin failures++; $display("FAIL period_100: got %0d expected 100", period); end
        checks++; if (period_valid !== 1'b1) begin failures++; $display("FAIL period_valid: got %0b expected 1", period_valid); end
        at(r0 + 150); photo_in = 1'b0;
        at(r0 + 250); photo_in = 1'b1;
        at(r0 + 257);
        checks++; if (period !== 8'd150) begin failures++; $display("FAIL period_150: got %0d expected 150", period); end
        checks++; if (total_cnt !== 32'd3) begin failures++; $display("FAIL total_3: got %0d expected 3", total_cnt); end
        at(r0 + 300); photo_in = 1'b0;
    endtask

    task automatic test_stall(input int r0);
        at(r0 + 400);
        checks++; if (stalled !== 1'b0) begin failures++; $display("FAIL stall_early: got %0b expected 0", stalled); end
        at(r0 + 570); photo_in = 1'b1;
        at(r0 + 576);
        checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL stalled_set: got %0b expected 1", stalled); end
        checks++; if (period !== 8'd150) begin failures++; $display("FAIL period_hold: got %0d expected 150", period); end
        at(r0 + 577);
        checks++; if (period !== 8'd255) begin failures++; $display("FAIL period_clamp: got %0d expected 255", period); end
        checks++; if (stalled !== 1'b0) begin failures++; $display("FAIL stalled_clear: got %0b expected 0", stalled); end
        at(r0 + 600); photo_in = 1'b0;
    endtask

    task automatic test_window();
        int m;
        tick(1);
        clr = 1'b1; m = cyc;
        tick(1); clr = 1'b0;
        checks++; if (total_cnt !== '0) begin failures++; $display("FAIL clr_total: got %0d expected 0", total_cnt); end
        checks++; if (period !== '0) begin failures++; $display("FAIL clr_period: got %0d expected 0", period); end
        checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL clr_period_valid: got %0b expected 0", period_valid); end
        checks++; if (stalled !== 1'b0) begin failures++; $display("FAIL clr_stalled: got %0b expected 0", stalled); end
        win_q.push_back(16'd7);
        win_q.push_back(16'd0);
        sb_on = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            at(m + 100 * i);      photo_in = 1'b1;
            at(m + 100 * i + 20); photo_in = 1'b0;
        end
        // Rise timed so its edge event sits on the gate terminal cycle.
        at(m + 994); photo_in = 1'b1;
        at(m + 1002);
        checks++; if (win_done !== 1'b0) begin failures++; $display("FAIL win_done_width: got %0b expected 0", win_done); end
        checks++; if (total_cnt !== 32'd7) begin failures++; $display("FAIL window_total: got %0d expected 7", total_cnt); end
        at(m + 1014); photo_in = 1'b0;
        at(m + 2003);
        checks++; if (win_q.size() !== 0) begin failures++; $display("FAIL window_pending: got %0d outstanding expected 0", win_q.size()); end
        sb_on = 1'b0;
        win_q.delete();
    endtask

    task automatic test_irq_clr();
        int p;
        int q;
        irq_en = 1'b1;
        tick(1);
        clr = 1'b1; p = cyc;
        tick(1); clr = 1'b0;
        win_q.push_back(16'd2);
        win_q.push_back(16'd3);
        sb_on = 1'b1;
        at(p + 300);  photo_in = 1'b1;
        at(p + 320);  photo_in = 1'b0;
        at(p + 500);  photo_in = 1'b1;
        at(p + 520);  photo_in = 1'b0;
        at(p + 1001);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early: got %0b expected 0", irq); end
        at(p + 1002);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set: got %0b expected 1", irq); end
        for (int i = 0; i < 3; i++) begin
            at(p + 1300 + 100 * i); photo_in = 1'b1;
            at(p + 1320 + 100 * i); photo_in = 1'b0;
        end
        at(p + 2001); irq_ack = 1'b1;
        at(p + 2002); irq_ack = 1'b0;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins: got %0b expected 1", irq); end
        at(p + 2010); irq_en = 1'b0;
        at(p + 2012);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_en_off_hold: got %0b expected 1", irq); end
        at(p + 2500); clr = 1'b1; q = cyc;
        at(q + 1); clr = 1'b0;
        checks++; if (total_cnt !== '0) begin failures++; $display("FAIL midclr_total: got %0d expected 0", total_cnt); end
        checks++; if (win_cnt !== '0) begin failures++; $display("FAIL midclr_win_cnt: got %0d expected 0", win_cnt); end
        checks++; if (period !== '0) begin failures++; $display("FAIL midclr_period: got %0d expected 0", period); end
        checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL midclr_valid: got %0b expected 0", period_valid); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL midclr_irq: got %0b expected 1", irq); end
        win_q.push_back(16'd1);
        at(q + 100); photo_in = 1'b1;
        at(q + 110);
        checks++; if (total_cnt !== 32'd1) begin failures++; $display("FAIL armed_total: got %0d expected 1", total_cnt); end
        checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL armed_first_edge: got %0b expected 0", period_valid); end
        at(q + 120); photo_in = 1'b0;
        at(q + 1002);
        checks++; if (win_q.size() !== 0) begin failures++; $display("FAIL irq_windows_pending: got %0d outstanding expected 0", win_q.size()); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_no_set_when_disabled: got %0b expected 1", irq); end
        irq_ack = 1'b1;
        at(q + 1003); irq_ack = 1'b0;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_ack: got %0b expected 0", irq); end
        sb_on = 1'b0;
    endtask

    initial begin
        int r0;
        @(negedge ACLK);
        test_reset();
        test_debounce(r0);
        test_period(r0);
        test_stall(r0);
        test_window();
        test_irq_clr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
